// File: rtl/median_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : median_pkg
//  Description : Shared types and schedule helpers for the median sequencer.
//                Pass schedule: P=(N+1)/2 passes; pass p compares for
//                N-1-p cycles, then bypasses for the rest of its N cycles.
//                The last pass ends right after its compare cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
package median_pkg;

  typedef enum logic [0:0] {
    LOAD = 1'b0,
    SORT = 1'b1
  } state_e;

  // Number of bubble passes needed until the median settles in MED's
  // last register.
  function automatic int n_passes(input int n);
    return (n + 1) / 2;
  endfunction

  // Compare cycles in pass p. The last pass (p = P-1) yields N-P.
  function automatic int cmp_len(input int n, input int p);
    return n - 1 - p;
  endfunction

  // Total SORT cycles from the end of LOAD until the median is ready.
  function automatic int sort_len(input int n);
    return (n_passes(n) - 1) * n + n - n_passes(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/median_seq_med.sv
`default_nettype none
// ============================================================================
//  Module      : med
//  Description : Compare/shift ring of N pixel registers. DO is the last
//                register, which holds the running maximum during compare
//                cycles. DSI=1 shifts DI in; BYP=1 rotates the ring
//                unchanged; otherwise the last register keeps the larger of
//                itself and its predecessor and the smaller is recycled to
//                the head of the ring.
//  Revision    : 1.0 - initial release
// ============================================================================
module med
  import median_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int N     = 9
) (
  input  logic             CLK,
  input  logic [WIDTH-1:0] DI,
  input  logic             DSI,
  input  logic             BYP,
  output logic [WIDTH-1:0] DO
);

  logic [WIDTH-1:0] r_q [N];
  logic [WIDTH-1:0] r_d [N];
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  // Next ring contents: load, plain rotate, or compare-exchange at the tail.
  always_comb begin
    hi = (r_q[N-1] >= r_q[N-2]) ? r_q[N-1] : r_q[N-2];
    lo = (r_q[N-1] >= r_q[N-2]) ? r_q[N-2] : r_q[N-1];
    for (int i = 0; i < N; i++) begin
      r_d[i] = r_q[i];
    end
    for (int i = 1; i < N - 1; i++) begin
      r_d[i] = r_q[i-1];
    end
    if (DSI) begin
      r_d[0]   = DI;
      r_d[N-1] = r_q[N-2];
    end else if (BYP) begin
      r_d[0]   = r_q[N-1];
      r_d[N-1] = r_q[N-2];
    end else begin
      r_d[0]   = lo;
      r_d[N-1] = hi;
    end
  end

  // Pixel registers carry no reset; their content is don't-care until loaded.
  always_ff @(posedge CLK) begin
    r_q <= r_d;
  end

  assign DO = r_q[N-1];

endmodule
`default_nettype wire

// File: rtl/median_seq.sv
`default_nettype none
// ============================================================================
//  Module      : median_seq
//  Description : Collects a burst of N pixels into MED, then drives MED's
//                DSI/BYP with the bubble-pass schedule that leaves the
//                median in MED's last register, and strobes DSO for one
//                cycle when DO holds the median.
//  Config      : MEDIAN_SEQ_OVR_EN adds a sticky OVR output that flags any
//                DSI sampled while sorting.
//  Revision    : 1.0 - initial release
// ============================================================================
module median_seq
  import median_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int N     = 9
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] DI,
  input  logic             DSI,
  output logic [WIDTH-1:0] DO,
`ifdef MEDIAN_SEQ_OVR_EN
  output logic             OVR,
`endif
  output logic             DSO
);

  localparam int P  = n_passes(N);
  localparam int CW = $clog2(N);
  localparam int PW = $clog2(P);

  localparam logic [CW-1:0] CNT_LAST  = CW'(N - 1);
  localparam logic [PW-1:0] PASS_LAST = PW'(P - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] pass_q, pass_d;
  logic          dso_q, dso_d;
  logic          med_dsi;
  logic          med_byp;
  logic [CW-1:0] cmp_cur;

  // Sequencer state, counters and the registered DSO strobe.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= LOAD;
      cnt_q   <= '0;
      pass_q  <= '0;
      dso_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pass_q  <= pass_d;
      dso_q   <= dso_d;
    end
  end

  // Next-state logic and MED control for load and sort passes.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pass_d  = pass_q;
    dso_d   = 1'b0;
    med_dsi = 1'b0;
    med_byp = 1'b1;
    cmp_cur = CW'(cmp_len(N, int'(pass_q)));
    case (state_q)
      LOAD: begin
        med_dsi = DSI;
        if (DSI) begin
          if (cnt_q == CNT_LAST) begin
            state_d = SORT;
            cnt_d   = '0;
            pass_d  = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end else begin
          // A gap before N samples discards the partial window.
          cnt_d = '0;
        end
      end
      SORT: begin
        med_byp = (cnt_q < cmp_cur) ? 1'b0 : 1'b1;
        if ((pass_q == PASS_LAST) && (cnt_q == cmp_cur - CW'(1))) begin
          state_d = LOAD;
          cnt_d   = '0;
          pass_d  = '0;
          dso_d   = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d  = '0;
          pass_d = pass_q + PW'(1);
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = LOAD;
        cnt_d   = '0;
        pass_d  = '0;
      end
    endcase
  end

`ifdef MEDIAN_SEQ_OVR_EN
  logic ovr_q;

  // Sticky overrun flag: any DSI seen while sorting, cleared only by reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      ovr_q <= 1'b0;
    end else if ((state_q == SORT) && DSI) begin
      ovr_q <= 1'b1;
    end
  end

  assign OVR = ovr_q;
`endif

  med #(
    .WIDTH (WIDTH),
    .N     (N)
  ) u_med (
    .CLK (CLK),
    .DI  (DI),
    .DSI (med_dsi),
    .BYP (med_byp),
    .DO  (DO)
  );

  assign DSO = dso_q;

endmodule
`default_nettype wire

// File: tb/tb_median_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_median_seq
//  Description : Scoreboard bench for median_seq (WIDTH=8, N=9). Each window
//                pushes its hand-computed median and the cycle its DSO must
//                appear in; a monitor pops on every DSO and compares.
//  Config      : MEDIAN_SEQ_OVR_EN enables the OVR checks.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_median_seq;

  localparam int WIDTH = 8;
  localparam int N     = 9;
  localparam int LAT   = 49;  // N + sort length for N=9

  logic             CLK;
  logic             RST;
  logic [WIDTH-1:0] DI;
  logic             DSI;
  logic [WIDTH-1:0] DO;
  logic             DSO;
`ifdef MEDIAN_SEQ_OVR_EN
  logic             OVR;
`endif

  typedef struct {
    logic [WIDTH-1:0] val;
    int               cyc;
  } exp_t;

  exp_t             sb_q [$];
  int               n_cmp = 0;
  int               n_bad = 0;
  int               cyc   = 0;
  logic [WIDTH-1:0] win [N];

  median_seq #(
    .WIDTH (WIDTH),
    .N     (N)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .DI  (DI),
    .DSI (DSI),
    .DO  (DO),
`ifdef MEDIAN_SEQ_OVR_EN
    .OVR (OVR),
`endif
    .DSO (DSO)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Cycle counter: value seen after a posedge names the current cycle.
  always @(posedge CLK) cyc <= cyc + 1;

  // Monitor: every DSO must match the oldest expected result, value and cycle.
  always @(negedge CLK) begin
    if (!RST && DSO) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_dso: DSO high at cycle %0d with DO=%0d, no result pending", cyc, DO);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        n_cmp++;
        if (DO !== e.val) begin
          n_bad++;
          $display("FAIL median_value: DO=%0d expected %0d (cycle %0d)", DO, e.val, cyc);
        end
        n_cmp++;
        if (cyc != e.cyc) begin
          n_bad++;
          $display("FAIL dso_cycle: DSO at cycle %0d expected cycle %0d", cyc, e.cyc);
        end
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    DSI = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  // Drives win[] on N consecutive cycles; optionally expects a result.
  task automatic send_window(input logic [WIDTH-1:0] med_exp, input bit expect_dso);
    exp_t e;
    e.val = med_exp;
    e.cyc = cyc + LAT;
    if (expect_dso) sb_q.push_back(e);
    for (int i = 0; i < N; i++) begin
      DSI = 1'b1;
      DI  = win[i];
      tick();
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    end
  endtask

  initial begin
    RST = 1'b1;
    DSI = 1'b0;
    DI  = '0;
    tick();
    tick();
    tick();
    chk("reset_dso", {31'd0, DSO}, 32'd0);
`ifdef MEDIAN_SEQ_OVR_EN
    chk("reset_ovr", {31'd0, OVR}, 32'd0);
`endif
    RST = 1'b0;
    tick();

    // Ascending ramp.
    win = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9};
    send_window(8'd5, 1'b1);
    idle(45);

    // Descending ramp.
    win = '{8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
    send_window(8'd5, 1'b1);
    idle(45);

    // Duplicates and extremes.
    win = '{8'd7, 8'd7, 8'd7, 8'd0, 8'd0, 8'd0, 8'd255, 8'd255, 8'd3};
    send_window(8'd7, 1'b1);
    idle(45);

    // Aborted 4-sample burst, gap of 3, then a full window.
    for (int i = 0; i < 4; i++) begin
      DSI = 1'b1;
      DI  = 8'd200;
      tick();
    end
    idle(3);
    win = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70, 8'd80, 8'd90};
    send_window(8'd50, 1'b1);
    idle(45);

    // Back-to-back: second burst starts in the first window's DSO cycle.
    win = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9};
    send_window(8'd5, 1'b1);
    idle(LAT - N);
    win = '{8'd11, 8'd22, 8'd33, 8'd44, 8'd55, 8'd66, 8'd77, 8'd88, 8'd99};
    send_window(8'd55, 1'b1);
    idle(45);

    // Reset in sort cycle 20 drops the window.
    win = '{8'd9, 8'd1, 8'd8, 8'd2, 8'd7, 8'd3, 8'd6, 8'd4, 8'd5};
    send_window(8'd5, 1'b0);
    idle(20);
    RST = 1'b1;
    tick();
    chk("mid_reset_dso", {31'd0, DSO}, 32'd0);
    RST = 1'b0;
    idle(60);
    win = '{8'd4, 8'd4, 8'd4, 8'd4, 8'd4, 8'd4, 8'd4, 8'd4, 8'd4};
    send_window(8'd4, 1'b1);
    idle(45);

`ifdef MEDIAN_SEQ_OVR_EN
    chk("ovr_before", {31'd0, OVR}, 32'd0);
    win = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9};
    send_window(8'd5, 1'b1);
    idle(5);
    DSI = 1'b1;
    DI  = 8'd0;
    tick();
    DSI = 1'b0;
    chk("ovr_set", {31'd0, OVR}, 32'd1);
    idle(45);
    win = '{8'd11, 8'd22, 8'd33, 8'd44, 8'd55, 8'd66, 8'd77, 8'd88, 8'd99};
    send_window(8'd55, 1'b1);
    idle(45);
    chk("ovr_sticky", {31'd0, OVR}, 32'd1);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk("ovr_clear", {31'd0, OVR}, 32'd0);
    tick();
`endif

    // Every pushed result must have been seen within a bounded wait.
    for (int i = 0; i < 100 && sb_q.size() != 0; i++) tick();
    chk("pending_results", sb_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
